cabs_rr_sched: RTL and testbench
================================

# cabs_rr_sched

Round-robin scheduler that shares one fixed-latency complex-magnitude engine (squares, add, log2/antilog) between NUM_CH I/Q channels. Each channel has a one-entry holding register with valid/ready handshake. The scheduler issues at most one sample per cycle into the engine and carries a channel tag through a delay line matched to the engine latency. It sits between the per-antenna I/Q front ends and the magnitude consumers (detection/peak logic), so one engine replaces NUM_CH instances.

## Interface
- NUM_CH, 4, number of requesting channels (2..16)
- DIN_WIDTH, 12, I/Q sample width, two's complement
- DOUT_WIDTH, 34, engine result width
- PIPE_LAT, 6, engine latency in cycles from registered operands to valid eng_dout (≥1)
- CH_W, derived = max(1, clog2(NUM_CH)), channel index width
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- s_valid  in  NUM_CH  per-channel sample valid
- s_ready  out  NUM_CH  per-channel holding register can accept
- s_i  in  NUM_CH*DIN_WIDTH  I samples, channel k at [k*DIN_WIDTH +: DIN_WIDTH]
- s_q  in  NUM_CH*DIN_WIDTH  Q samples, same packing
- eng_dina  out  DIN_WIDTH  registered I operand to engine
- eng_dinb  out  DIN_WIDTH  registered Q operand to engine
- eng_dout  in  DOUT_WIDTH  engine result
- m_valid  out  1  result valid (single-cycle pulse, no backpressure)
- m_ch  out  CH_W  channel of current result
- m_data  out  DOUT_WIDTH  magnitude result
- busy  out  1  any holding register or tag stage valid
- peak  out  NUM_CH*DOUT_WIDTH  per-channel peak hold (CABS_SCHED_PEAK_EN only)
- peak_clr  in  NUM_CH  per-channel peak clear (CABS_SCHED_PEAK_EN only)

## Operation
- Holding register k loads {s_i, s_q} on s_valid[k] & s_ready[k]; s_ready[k] = ~hold_vld[k] | grant[k] (same-cycle refill allowed).
- Arbiter: among hold_vld, grant the first set bit at or after rr_ptr (cyclic); on grant, rr_ptr <= granted+1 mod NUM_CH. No grant leaves rr_ptr unchanged.
- On grant, eng_dina/eng_dinb <= held I/Q; hold_vld cleared unless refilled the same cycle. Without grant, eng_dina/eng_dinb <= 0 (engine is free-running; zeros keep power and tag alignment deterministic).
- Tag pipe: PIPE_LAT+1 stages of {vld, ch}; stage 0 loads {grant_any, grant_idx} on the same edge as the operands.
- The last tag stage drives m_valid and m_ch. m_data = eng_dout in that cycle, passed through without a register. eng_dout is ignored when the tag is invalid.
- Data is passed raw. Sign handling and magnitude arithmetic belong to the engine.
- Starvation bound: a held sample is granted within NUM_CH cycles.

## Timing
- Reset values: s_ready all 1, eng_dina/eng_dinb 0, m_valid 0, m_ch 0, m_data follows eng_dout, busy 0, rr_ptr 0, all hold_vld/tag vld 0, peak 0.
- Uncontended latency: accept at edge t → held from t; grant and operand register at edge t+1 → m_valid high in cycle t+1+PIPE_LAT.
- Throughput: 1 result/cycle aggregate; 1 sample/cycle per channel when that channel is the only requester.
- Reset mid-operation: all in-flight tags are dropped, so no m_valid appears for samples accepted before reset. Engine contents are don't-care.
- All channels valid continuously: grants rotate 0,1,…,NUM_CH-1,0.

## Configuration
- CABS_SCHED_PEAK_EN defined: per-channel peak register.
  - On m_valid for channel k, peak[k] <= max(peak[k], m_data).
  - peak_clr[k] loads 0, or loads m_data if a channel-k result lands in the same cycle (clear wins over the old value, the new sample is kept).
- Not defined: peak and peak_clr ports are absent and no peak logic is built.

## Structure
- Package cabs_sched_pkg holds:
  - CH_W derivation function (clog2 with minimum 1)
  - tag struct typedef {vld, ch}
  - default PIPE_LAT constant matching the current magnitude engine build
- One sub-module, rr_arbiter: NUM_CH request vector plus pointer in, one-hot grant and index out, purely combinational. It is reusable by other shared math engines.

## Test plan
Bench uses a behavioural engine model with exact PIPE_LAT delay and output = I²+Q² tagged onto eng_dout.
- Ch2 sends I=3, Q=4 once, others idle → m_valid single pulse 1+PIPE_LAT cycles after acceptance, m_ch=2, m_data=25; busy drops the cycle after.
- All four channels hold s_valid high for 40 cycles with distinct ramps → m_ch sequence 0,1,2,3 repeating, 10 results per channel, no loss, per-channel order preserved, s_ready never low more than 3 consecutive cycles.
- Ch0 continuous, ch3 single sample arriving mid-stream → ch3 result appears within 4 cycles of grant eligibility; ch0 stream resumes at 1/cycle.
- Ch1 samples I=-2048, Q=-2048 → eng_dina=eng_dinb=12'h800 passed unchanged; m_data = model(8388608).
- Assert rst for 1 cycle while 3 samples are in flight → no m_valid for them; a fresh ch0 sample after reset returns with normal latency and rr_ptr restarts at 0.
- PEAK_EN: ch1 results 9, 25, 16 → peak[1]=25; peak_clr[1] coincident with result 4 → peak[1]=4.

Source files
------------

// File: rtl/cabs_sched_pkg.sv
// cabs_sched_pkg: shared types and constants for the complex-magnitude
// round-robin scheduler and its arbiter.
//   PIPE_LAT_DEFAULT : latency of the current magnitude engine build
//   TAG_CH_W         : tag channel field width, covers up to 16 channels
//   ch_w_f()         : channel index width, clog2 with a floor of 1
//   tag_t            : {vld, ch} entry of the tag delay line
package cabs_sched_pkg;

    localparam int PIPE_LAT_DEFAULT = 6;
    localparam int TAG_CH_W         = 4;

    function automatic int ch_w_f(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                vld;
        logic [TAG_CH_W-1:0] ch;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
// Grants the first set request at or after ptr_i, wrapping at NUM_CH.
// Ports:
//   req_i [NUM_CH]  request vector
//   ptr_i [CH_W]    search start index (must be < NUM_CH)
//   gnt_o [NUM_CH]  one-hot grant
//   idx_o [CH_W]    index of the granted request
//   any_o           a grant was issued
module rr_arbiter
    import cabs_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = ch_w_f(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [CH_W-1:0]   idx_o,
    output logic              any_o
);

    logic [CH_W:0]   sum;
    logic [CH_W-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            // ptr + k stays below 2*NUM_CH, so one conditional subtract wraps it
            sum  = {1'b0, ptr_i} + (CH_W+1)'(k);
            cand = (sum >= (CH_W+1)'(NUM_CH)) ? CH_W'(sum - (CH_W+1)'(NUM_CH))
                                              : sum[CH_W-1:0];
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/cabs_rr_sched.sv
// cabs_rr_sched: shares one fixed-latency complex-magnitude engine between
// NUM_CH I/Q channels. Each channel owns a one-entry holding register; a
// round-robin arbiter issues at most one sample per cycle into the engine and
// a channel tag travels through a delay line matched to the engine latency.
// Optional feature macro: CABS_SCHED_PEAK_EN adds per-channel peak hold
// (ports peak / peak_clr exist only when it is defined).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   s_valid/s_ready     per-channel handshake
//   s_i/s_q             packed I/Q samples, channel k at [k*DIN_WIDTH +: DIN_WIDTH]
//   eng_dina/eng_dinb   registered I/Q operands to the engine (0 when idle)
//   eng_dout            engine result, PIPE_LAT cycles after the operands
//   m_valid/m_ch/m_data tagged result (m_data is eng_dout passed through)
//   busy                any holding register or tag stage occupied
//   peak/peak_clr       per-channel peak hold and clear (CABS_SCHED_PEAK_EN)
module cabs_rr_sched
    import cabs_sched_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DIN_WIDTH  = 12,
    parameter int DOUT_WIDTH = 34,
    parameter int PIPE_LAT   = PIPE_LAT_DEFAULT,
    localparam int CH_W      = ch_w_f(NUM_CH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              s_valid,
    output logic [NUM_CH-1:0]              s_ready,
    input  logic [NUM_CH*DIN_WIDTH-1:0]    s_i,
    input  logic [NUM_CH*DIN_WIDTH-1:0]    s_q,
    output logic signed [DIN_WIDTH-1:0]    eng_dina,
    output logic signed [DIN_WIDTH-1:0]    eng_dinb,
    input  logic [DOUT_WIDTH-1:0]          eng_dout,
    output logic                           m_valid,
    output logic [CH_W-1:0]                m_ch,
    output logic [DOUT_WIDTH-1:0]          m_data,
    output logic                           busy
`ifdef CABS_SCHED_PEAK_EN
    ,
    output logic [NUM_CH*DOUT_WIDTH-1:0]   peak,
    input  logic [NUM_CH-1:0]              peak_clr
`endif
);

    logic [NUM_CH-1:0]           hold_vld_q, hold_vld_d;
    logic signed [DIN_WIDTH-1:0] hold_i_q [NUM_CH];
    logic signed [DIN_WIDTH-1:0] hold_q_q [NUM_CH];
    logic [CH_W-1:0]             rr_ptr_q, rr_ptr_d;
    logic signed [DIN_WIDTH-1:0] dina_q, dina_d, dinb_q, dinb_d;
    logic [NUM_CH-1:0]           gnt, load;
    logic [CH_W-1:0]             gnt_idx;
    logic                        gnt_any;
    tag_t                        tag_q [PIPE_LAT+1];
    logic [TAG_CH_W-1:0]         unused_tag_ch;

    rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
        .req_i (hold_vld_q),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    // Stage boundary: input handshake / holding registers -> engine operands
    always_comb begin
        // a granted slot frees up this cycle, so it can be refilled on the same edge
        s_ready    = ~hold_vld_q | gnt;
        load       = s_valid & s_ready;
        hold_vld_d = (hold_vld_q & ~gnt) | load;
        rr_ptr_d   = rr_ptr_q;
        dina_d     = '0;
        dinb_d     = '0;
        if (gnt_any) begin
            dina_d   = hold_i_q[gnt_idx];
            dinb_d   = hold_q_q[gnt_idx];
            rr_ptr_d = (gnt_idx == CH_W'(NUM_CH-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (load[k]) begin
                hold_i_q[k] <= s_i[k*DIN_WIDTH +: DIN_WIDTH];
                hold_q_q[k] <= s_q[k*DIN_WIDTH +: DIN_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_vld_q <= '0;
            rr_ptr_q   <= '0;
            dina_q     <= '0;
            dinb_q     <= '0;
            for (int s = 0; s <= PIPE_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            hold_vld_q   <= hold_vld_d;
            rr_ptr_q     <= rr_ptr_d;
            dina_q       <= dina_d;
            dinb_q       <= dinb_d;
            // Stage boundary: tag delay line, aligned with the engine pipeline
            tag_q[0].vld <= gnt_any;
            tag_q[0].ch  <= TAG_CH_W'(gnt_idx);
            for (int s = 1; s <= PIPE_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign eng_dina = dina_q;
    assign eng_dinb = dinb_q;

    // Stage boundary: engine output -> tagged result (unregistered pass-through)
    assign m_valid       = tag_q[PIPE_LAT].vld;
    assign m_ch          = tag_q[PIPE_LAT].ch[CH_W-1:0];
    assign m_data        = eng_dout;
    assign unused_tag_ch = tag_q[PIPE_LAT].ch;

    always_comb begin
        busy = |hold_vld_q;
        for (int s = 0; s <= PIPE_LAT; s++) begin
            busy = busy | tag_q[s].vld;
        end
    end

`ifdef CABS_SCHED_PEAK_EN
    logic [DOUT_WIDTH-1:0] peak_q [NUM_CH];

    // clear has priority over the old peak but keeps a result landing on the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                peak_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (peak_clr[k]) begin
                    peak_q[k] <= (m_valid && m_ch == CH_W'(k)) ? m_data : '0;
                end else if (m_valid && m_ch == CH_W'(k) && m_data > peak_q[k]) begin
                    peak_q[k] <= m_data;
                end
            end
        end
    end

    always_comb begin
        peak = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            peak[k*DOUT_WIDTH +: DOUT_WIDTH] = peak_q[k];
        end
    end
`endif

endmodule

// File: tb/tb_cabs_rr_sched.sv
// Directed testbench for cabs_rr_sched with a behavioural magnitude engine
// (I*I + Q*Q after exactly PIPE_LAT cycles).
module tb_cabs_rr_sched;

    localparam int NUM_CH     = 4;
    localparam int DIN_WIDTH  = 12;
    localparam int DOUT_WIDTH = 34;
    localparam int PIPE_LAT   = 6;
    localparam int CH_W       = 2;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [NUM_CH-1:0]            s_valid;
    logic [NUM_CH-1:0]            s_ready;
    logic [NUM_CH*DIN_WIDTH-1:0]  s_i;
    logic [NUM_CH*DIN_WIDTH-1:0]  s_q;
    logic signed [DIN_WIDTH-1:0]  eng_dina;
    logic signed [DIN_WIDTH-1:0]  eng_dinb;
    logic [DOUT_WIDTH-1:0]        eng_dout;
    logic                         m_valid;
    logic [CH_W-1:0]              m_ch;
    logic [DOUT_WIDTH-1:0]        m_data;
    logic                         busy;
`ifdef CABS_SCHED_PEAK_EN
    logic [NUM_CH*DOUT_WIDTH-1:0] peak;
    logic [NUM_CH-1:0]            peak_clr;
`endif

    always #5 clk = ~clk;

    cabs_rr_sched #(
        .NUM_CH(NUM_CH), .DIN_WIDTH(DIN_WIDTH),
        .DOUT_WIDTH(DOUT_WIDTH), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_i(s_i), .s_q(s_q), .eng_dina(eng_dina), .eng_dinb(eng_dinb),
        .eng_dout(eng_dout), .m_valid(m_valid), .m_ch(m_ch),
        .m_data(m_data), .busy(busy)
`ifdef CABS_SCHED_PEAK_EN
        , .peak(peak), .peak_clr(peak_clr)
`endif
    );

    function automatic logic [DOUT_WIDTH-1:0] sq_sum(input int a, input int b);
        longint r;
        r = longint'(a) * longint'(a) + longint'(b) * longint'(b);
        return DOUT_WIDTH'(r);
    endfunction

    // behavioural engine: fixed PIPE_LAT delay from registered operands
    logic [DOUT_WIDTH-1:0] eng_pipe [PIPE_LAT];
    always @(posedge clk) begin
        eng_pipe[0] <= sq_sum(int'(eng_dina), int'(eng_dinb));
        for (int s = 1; s < PIPE_LAT; s++) eng_pipe[s] <= eng_pipe[s-1];
    end
    assign eng_dout = eng_pipe[PIPE_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int                    res_ch[$];
    logic [DOUT_WIDTH-1:0] res_data[$];
    int                    res_cyc[$];
    always @(negedge clk) begin
        if (m_valid === 1'b1) begin
            res_ch.push_back(int'(m_ch));
            res_data.push_back(m_data);
            res_cyc.push_back(cyc);
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        res_ch.delete();
        res_data.delete();
        res_cyc.delete();
    endtask

    task automatic set_ch(input int k, input int i, input int q);
        s_i[k*DIN_WIDTH +: DIN_WIDTH] = DIN_WIDTH'(i);
        s_q[k*DIN_WIDTH +: DIN_WIDTH] = DIN_WIDTH'(q);
    endtask

    task automatic do_reset();
        s_valid = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // single-channel send; returns the cycle count right after the accepting edge
    task automatic send1(input int k, input int i, input int q, output int acc);
        s_valid = '0;
        set_ch(k, i, q);
        s_valid[k] = 1'b1;
        tick();
        acc = cyc;
        s_valid = '0;
    endtask

    task automatic wait_mv(input int bound, input string tag);
        int w = 0;
        while (m_valid !== 1'b1 && w < bound) begin
            tick();
            w++;
        end
        if (m_valid !== 1'b1) check(tag, 64'(0), 64'(1));
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int w = 0;
        while (busy !== 1'b0 && w < bound) begin
            tick();
            w++;
        end
        check(tag, 64'(busy), 64'(0));
    endtask

    task automatic test_single();
        int a;
        do_reset();
        clear_q();
        send1(2, 3, 4, a);
        tick();
        check("t1_dina", {52'b0, eng_dina}, 64'd3);
        check("t1_dinb", {52'b0, eng_dinb}, 64'd4);
        wait_mv(20, "t1_timeout");
        check("t1_lat", 64'(cyc - a), 64'(1 + PIPE_LAT));
        check("t1_ch", 64'(m_ch), 64'd2);
        check("t1_data", 64'(m_data), 64'd25);
        check("t1_busy_hi", 64'(busy), 64'd1);
        tick();
        check("t1_pulse", 64'(m_valid), 64'd0);
        check("t1_busy_lo", 64'(busy), 64'd0);
    endtask

    task automatic test_all_ch();
        int n[NUM_CH];
        int run[NUM_CH];
        int mx[NUM_CH];
        int idx[NUM_CH];
        int c;
        logic [NUM_CH-1:0] rdy;
        logic done;
        do_reset();
        clear_q();
        for (int k = 0; k < NUM_CH; k++) begin
            n[k] = 0; run[k] = 0; mx[k] = 0; idx[k] = 0;
        end
        for (int it = 0; it < 200; it++) begin
            done = 1'b1;
            for (int k = 0; k < NUM_CH; k++) begin
                s_valid[k] = (n[k] < 10);
                if (n[k] < 10) done = 1'b0;
                set_ch(k, k * 16 + n[k], n[k] + 1);
            end
            if (done) break;
            rdy = s_ready;
            for (int k = 0; k < NUM_CH; k++) begin
                if (s_valid[k]) begin
                    if (!rdy[k]) begin
                        run[k]++;
                        if (run[k] > mx[k]) mx[k] = run[k];
                    end else begin
                        run[k] = 0;
                    end
                end
            end
            tick();
            for (int k = 0; k < NUM_CH; k++) begin
                if (s_valid[k] && rdy[k]) n[k]++;
            end
        end
        s_valid = '0;
        wait_idle(60, "t2_idle");
        check("t2_cnt", 64'(res_ch.size()), 64'd40);
        for (int i = 0; i < res_ch.size(); i++) begin
            c = res_ch[i];
            check("t2_ch", 64'(c), 64'(i % NUM_CH));
            if (c < NUM_CH) begin
                check("t2_data", 64'(res_data[i]), 64'(sq_sum(c * 16 + idx[c], idx[c] + 1)));
                idx[c]++;
            end
        end
        for (int k = 0; k < NUM_CH; k++) check("t2_rdy_run", 64'(mx[k]), 64'd3);
    endtask

    task automatic test_late_ch3();
        int n0 = 0;
        int a3 = -1;
        int n3 = 0;
        int first0 = -1;
        int last0 = -1;
        int k0 = 0;
        logic [NUM_CH-1:0] rdy;
        do_reset();
        clear_q();
        for (int it = 0; it < 100 && n0 < 20; it++) begin
            s_valid = '0;
            s_valid[0] = 1'b1;
            set_ch(0, n0 + 1, 0);
            if (it == 8) begin
                s_valid[3] = 1'b1;
                set_ch(3, 5, 5);
            end
            rdy = s_ready;
            tick();
            if (rdy[0]) n0++;
            if (it == 8 && rdy[3]) a3 = cyc;
        end
        s_valid = '0;
        wait_idle(40, "t3_idle");
        for (int i = 0; i < res_ch.size(); i++) begin
            if (res_ch[i] == 3) begin
                n3++;
                check("t3_ch3_data", 64'(res_data[i]), 64'd50);
                check("t3_ch3_lat", 64'(res_cyc[i] - a3), 64'(1 + PIPE_LAT));
            end else begin
                k0++;
                check("t3_ch0_data", 64'(res_data[i]), 64'(k0 * k0));
                if (first0 < 0) first0 = res_cyc[i];
                last0 = res_cyc[i];
            end
        end
        check("t3_ch3_cnt", 64'(n3), 64'd1);
        check("t3_ch0_cnt", 64'(k0), 64'd20);
        check("t3_ch0_span", 64'(last0 - first0), 64'd20);
    endtask

    task automatic test_neg_full();
        int a;
        clear_q();
        send1(1, -2048, -2048, a);
        tick();
        check("t4_dina", {52'b0, eng_dina}, 64'h800);
        check("t4_dinb", {52'b0, eng_dinb}, 64'h800);
        wait_mv(20, "t4_timeout");
        check("t4_ch", 64'(m_ch), 64'd1);
        check("t4_data", 64'(m_data), 64'd8388608);
        tick();
    endtask

    task automatic test_mid_reset();
        int a;
        clear_q();
        s_valid = '0;
        set_ch(0, 1, 1);
        set_ch(1, 2, 2);
        set_ch(2, 3, 3);
        s_valid = 4'b0111;
        tick();
        s_valid = '0;
        tick();
        rst = 1'b1;
        #1;
        check("t5_rst_ready", 64'(s_ready), 64'hF);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_mvalid", 64'(m_valid), 64'd0);
        check("t5_rst_dina", {52'b0, eng_dina}, 64'd0);
        tick();
        rst = 1'b0;
        for (int w = 0; w < 15; w++) tick();
        check("t5_dropped", 64'(res_ch.size()), 64'd0);
        // ch0 and ch3 together: a restarted pointer serves ch0 first
        set_ch(0, 7, 0);
        set_ch(3, 0, 8);
        s_valid = 4'b1001;
        tick();
        a = cyc;
        s_valid = '0;
        for (int w = 0; w < 30 && res_ch.size() < 2; w++) tick();
        check("t5_cnt", 64'(res_ch.size()), 64'd2);
        if (res_ch.size() >= 2) begin
            check("t5_first_ch", 64'(res_ch[0]), 64'd0);
            check("t5_first_lat", 64'(res_cyc[0] - a), 64'(1 + PIPE_LAT));
            check("t5_first_data", 64'(res_data[0]), 64'd49);
            check("t5_second_ch", 64'(res_ch[1]), 64'd3);
            check("t5_second_data", 64'(res_data[1]), 64'd64);
        end
    endtask

`ifdef CABS_SCHED_PEAK_EN
    task automatic test_peak();
        int a;
        do_reset();
        check("t6_peak_rst", 64'(peak[1*DOUT_WIDTH +: DOUT_WIDTH]), 64'd0);
        send1(1, 3, 0, a); wait_mv(20, "t6_to_a"); tick();
        send1(1, 3, 4, a); wait_mv(20, "t6_to_b"); tick();
        send1(1, 4, 0, a); wait_mv(20, "t6_to_c"); tick();
        check("t6_peak_max", 64'(peak[1*DOUT_WIDTH +: DOUT_WIDTH]), 64'd25);
        send1(1, 2, 0, a);
        wait_mv(20, "t6_to_d");
        peak_clr = 4'b0010;
        tick();
        peak_clr = '0;
        check("t6_peak_clr", 64'(peak[1*DOUT_WIDTH +: DOUT_WIDTH]), 64'd4);
    endtask
`endif

    initial begin
        rst     = 1'b1;
        s_valid = '0;
        s_i     = '0;
        s_q     = '0;
`ifdef CABS_SCHED_PEAK_EN
        peak_clr = '0;
`endif
        tick();
        check("rst_ready", 64'(s_ready), 64'hF);
        check("rst_dina", {52'b0, eng_dina}, 64'd0);
        check("rst_dinb", {52'b0, eng_dinb}, 64'd0);
        check("rst_mvalid", 64'(m_valid), 64'd0);
        check("rst_mch", 64'(m_ch), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        tick();
        rst = 1'b0;

        test_single();
        test_all_ch();
        test_late_ch3();
        test_neg_full();
        test_mid_reset();
`ifdef CABS_SCHED_PEAK_EN
        test_peak();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
